// File: rtl/button_debounce_multi_pkg.sv
// Shared definitions for the multi-channel button debouncer: hold FSM
// encoding and a time-to-cycles helper for integrators.
package button_debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } hold_st_e;

  // Converts a duration in ms to clock cycles at clk_hz.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    logic [63:0] cyc;
    cyc = 64'(clk_hz) * 64'(ms) / 64'd1000;
    return cyc[31:0];
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: polarity normalise, 2-flop sync, debounce counter,
// and a hold FSM producing long-press and auto-repeat strobes.
module button_debounce_ch
  import button_debounce_multi_pkg::*;
#(
  parameter int DB_CYC     = 2_000_000,
  parameter int LONG_CYC   = 100_000_000,
  parameter int REP_CYC    = 20_000_000,
  parameter bit REPEAT_EN  = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_but,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat
);
  localparam int DB_W   = $clog2(DB_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam int REP_W  = $clog2(REP_CYC + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

  logic              w_raw, w_mis, w_flip, w_rise, w_fall;
  logic              w_hold_hit, w_rep_hit, w_long_set, w_rep_set;
  logic [1:0]        r_sync;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              r_level, r_press, r_release, r_long, r_rep;
  hold_st_e          r_state, w_state_nxt;

  assign w_raw = ACTIVE_LOW ? ~i_but : i_but;

  // Level flips only after DB_CYC consecutive mismatching samples.
  assign w_mis  = r_sync[1] != r_level;
  assign w_flip = w_mis && (r_db_cnt == DB_LAST);
  assign w_rise = w_flip && !r_level;
  assign w_fall = w_flip && r_level;

  assign w_hold_hit = r_hold_cnt == HOLD_LAST;
  assign w_rep_hit  = r_rep_cnt == REP_LAST;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_HELD;
      ST_HELD: if (w_fall) w_state_nxt = ST_IDLE;
               else if (w_hold_hit) w_state_nxt = ST_LONG;
      ST_LONG: if (w_fall) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A release landing on a threshold cycle suppresses the strobe.
  always_comb begin
    w_long_set = (r_state == ST_HELD) && !w_fall && w_hold_hit;
    w_rep_set  = REPEAT_EN && (r_state == ST_LONG) && !w_fall && w_rep_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_db_cnt   <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_long     <= 1'b0;
      r_rep      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], w_raw};
      r_db_cnt   <= (!w_mis || w_flip) ? '0 : r_db_cnt + 1'b1;
      r_level    <= r_level ^ w_flip;
      r_press    <= w_rise;
      r_release  <= w_fall;
      r_hold_cnt <= (r_state == ST_HELD) ? r_hold_cnt + 1'b1 : '0;
      r_rep_cnt  <= ((r_state == ST_LONG) && !w_rep_hit) ? r_rep_cnt + 1'b1 : '0;
      r_long     <= w_long_set;
      r_rep      <= w_rep_set;
    end
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_repeat     = r_rep;

endmodule

// File: rtl/button_debounce_multi.sv
// N_CH independent debounced button channels with a shared any-press flag.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int DB_CYC     = 2_000_000,
  parameter int LONG_CYC   = 100_000_000,
  parameter int REP_CYC    = 20_000_000,
  parameter bit REPEAT_EN  = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_but_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long_press,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any_press
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_debounce_ch #(
      .DB_CYC    (DB_CYC),
      .LONG_CYC  (LONG_CYC),
      .REP_CYC   (REP_CYC),
      .REPEAT_EN (REPEAT_EN),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_but       (i_but_in[g]),
      .o_level     (o_level[g]),
      .o_press     (o_press[g]),
      .o_release   (o_release[g]),
      .o_long_press(o_long_press[g]),
      .o_repeat    (o_repeat[g])
    );
  end

  // OR of registered strobes only; no path from the raw pins.
  assign o_any_press = |o_press;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Randomised and directed bench for button_debounce_multi against a
// sliding-window / elapsed-time reference model.
module tb_button_debounce_multi;
  localparam int N_CH = 2, DB_CYC = 4, LONG_CYC = 20, REP_CYC = 8, MAXC = 8192;
  localparam int PW = 5*N_CH + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N_CH-1:0] but = '0, but_n;
  logic [N_CH-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [N_CH-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
  logic [N_CH-1:0] lvl_c, prs_c, rel_c, lng_c, rep_c;
  logic any_a, any_b, any_c;

  always #5 clk = ~clk;
  assign but_n = ~but;

  button_debounce_multi #(.N_CH(N_CH), .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC),
    .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_but_in(but), .o_level(lvl_a), .o_press(prs_a),
    .o_release(rel_a), .o_long_press(lng_a), .o_repeat(rep_a), .o_any_press(any_a));

  button_debounce_multi #(.N_CH(N_CH), .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC),
    .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)) u_dut_al (
    .i_clk(clk), .i_rst_n(rst_n), .i_but_in(but_n), .o_level(lvl_b), .o_press(prs_b),
    .o_release(rel_b), .o_long_press(lng_b), .o_repeat(rep_b), .o_any_press(any_b));

  button_debounce_multi #(.N_CH(N_CH), .DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC),
    .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b0)) u_dut_nr (
    .i_clk(clk), .i_rst_n(rst_n), .i_but_in(but), .o_level(lvl_c), .o_press(prs_c),
    .o_release(rel_c), .o_long_press(lng_c), .o_repeat(rep_c), .o_any_press(any_c));

  int n_chk = 0, n_err = 0;
  int cyc = 0, base = 0;
  logic [N_CH-1:0] hist [MAXC];
  logic [N_CH-1:0] m_lvl = '0;
  int m_p [N_CH];
  int t_prs [N_CH], t_rel [N_CH], t_lng [N_CH];
  int t_any;
  int rep_q [$];
  logic [N_CH-1:0] saw = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] pk(input logic [N_CH-1:0] l, p, r, g, q, input logic a);
    return {l, p, r, g, q, a};
  endfunction

  function automatic logic raw_at(input int c, input int ch);
    if (c < base) return 1'b0;
    return hist[c][ch];
  endfunction

  // Model: the DUT sees the pin value from 3 cycles back; level flips once
  // DB_CYC consecutive seen values disagree with it. Hold strobes follow
  // from elapsed time since the press while level stays high.
  task automatic model_check(input int t);
    logic [N_CH-1:0] e_l, e_p, e_r, e_g, e_q;
    for (int ch = 0; ch < N_CH; ch++) begin
      logic stable, old, nw;
      int d;
      stable = 1'b1;
      for (int k = 0; k < DB_CYC; k++)
        if (raw_at(t - 3 - k, ch) == m_lvl[ch]) stable = 1'b0;
      old = m_lvl[ch];
      nw  = stable ? ~old : old;
      e_l[ch] = nw;
      e_p[ch] = !old && nw;
      e_r[ch] = old && !nw;
      e_g[ch] = 1'b0;
      e_q[ch] = 1'b0;
      if (e_p[ch]) m_p[ch] = t;
      if (old && nw) begin
        d = t - m_p[ch];
        e_g[ch] = (d == LONG_CYC);
        e_q[ch] = (d > LONG_CYC) && ((d - LONG_CYC) % REP_CYC == 0);
      end
      m_lvl[ch] = nw;
    end
    chk("outs", 32'(pk(lvl_a, prs_a, rel_a, lng_a, rep_a, any_a)), 32'(pk(e_l, e_p, e_r, e_g, e_q, |e_p)));
    chk("al_outs", 32'(pk(lvl_b, prs_b, rel_b, lng_b, rep_b, any_b)), 32'(pk(e_l, e_p, e_r, e_g, e_q, |e_p)));
    chk("nr_outs", 32'(pk(lvl_c, prs_c, rel_c, lng_c, rep_c, any_c)), 32'(pk(e_l, e_p, e_r, e_g, '0, |e_p)));
  endtask

  task automatic step(input logic [N_CH-1:0] b);
    but = b;
    hist[cyc] = b;
    @(posedge clk);
    cyc++;
    #1;
    model_check(cyc);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (prs_a[ch]) t_prs[ch] = cyc;
      if (rel_a[ch]) t_rel[ch] = cyc;
      if (lng_a[ch]) t_lng[ch] = cyc;
    end
    if (any_a) t_any = cyc;
    if (rep_a[1]) rep_q.push_back(cyc);
    saw |= lvl_a | prs_a | rel_a;
  endtask

  task automatic steps(input logic [N_CH-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic clr_log();
    for (int ch = 0; ch < N_CH; ch++) begin
      t_prs[ch] = -1; t_rel[ch] = -1; t_lng[ch] = -1;
    end
    t_any = -1;
    rep_q.delete();
    saw = '0;
  endtask

  task automatic mid_reset(input logic [N_CH-1:0] b);
    but = b;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(pk(lvl_a, prs_a, rel_a, lng_a, rep_a, any_a)), 32'd0);
    chk("async_rst_al", 32'(pk(lvl_b, prs_b, rel_b, lng_b, rep_b, any_b)), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    base = cyc;
    m_lvl = '0;
  endtask

  initial begin
    int off;
    int run [N_CH];
    logic [N_CH-1:0] v;
    clr_log();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(pk(lvl_a, prs_a, rel_a, lng_a, rep_a, any_a)), 32'd0);
    chk("reset_outs_nr", 32'(pk(lvl_c, prs_c, rel_c, lng_c, rep_c, any_c)), 32'd0);
    rst_n = 1'b1;

    // Clean press/release on ch0.
    off = cyc;
    steps(2'b01, 10);
    steps(2'b00, 15);
    chk("s1_press", 32'(t_prs[0] - off), 32'd6);
    chk("s1_any", 32'(t_any - off), 32'd6);
    chk("s1_release", 32'(t_rel[0] - off), 32'd16);
    chk("s1_nolong", 32'(t_lng[0]), 32'hffffffff);

    // Glitch followed by a bounce train of short pulses.
    clr_log();
    steps(2'b01, 3);
    steps(2'b00, 3);
    for (int i = 0; i < 30; ) begin
      int h = int'($urandom_range(1, 3));
      int l = int'($urandom_range(1, 3));
      steps(2'b01, h);
      steps(2'b00, l);
      i += h + l;
    end
    steps(2'b00, 8);
    chk("s2_quiet", 32'(saw), 32'd0);

    // Long hold on ch1 with repeats; release lands on a repeat threshold.
    clr_log();
    off = cyc;
    steps(2'b10, 60);
    steps(2'b00, 15);
    chk("s3_press", 32'(t_prs[1] - off), 32'd6);
    chk("s3_long", 32'(t_lng[1] - off), 32'd26);
    chk("s3_rep_n", 32'(rep_q.size()), 32'd4);
    for (int i = 0; i < rep_q.size() && i < 4; i++)
      chk("s3_rep_t", 32'(rep_q[i] - off), 32'(34 + 8*i));
    chk("s3_release", 32'(t_rel[1] - off), 32'd66);

    // Release on the long-press threshold cycle.
    clr_log();
    off = cyc;
    steps(2'b10, 20);
    steps(2'b00, 15);
    chk("s4_release", 32'(t_rel[1] - off), 32'd26);
    chk("s4_nolong", 32'(t_lng[1]), 32'hffffffff);

    // Reset mid-hold, button kept pressed across reset.
    clr_log();
    steps(2'b10, 30);
    mid_reset(2'b10);
    off = cyc;
    clr_log();
    steps(2'b10, 40);
    steps(2'b00, 15);
    chk("s5_press", 32'(t_prs[1] - off), 32'd6);
    chk("s5_long", 32'(t_lng[1] - off), 32'd26);

    // Random bouncy and long runs on both channels.
    v = '0;
    for (int ch = 0; ch < N_CH; ch++) run[ch] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (run[ch] == 0) begin
          v[ch] = ~v[ch];
          run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(4, 70));
        end
        run[ch]--;
      end
      if (i == 700) mid_reset(v);
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
